multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

- Multi-cycle control unit for the RV32I core; sequences fetch, decode, execute, memory and writeback over a shared ALU, a single unified memory port and the immediate extender.
- Drives every datapath select and write enable, including the 2-bit `immSrc` consumed by the sign-extension unit.
- Waits on a memory-ready handshake, counts retired instructions and traps on unsupported encodings.

## Interface
Parameters:
- `CNT_WIDTH`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op`  in  7  instruction[6:0], taken from the instruction register.
- `funct3`  in  3  instruction[14:12].
- `funct7b5`  in  1  instruction[30].
- `zero`  in  1  ALU zero flag.
- `memReady`  in  1  memory has completed the current access this cycle.
- `pcWrite`  out  1  PC register load.
- `adrSrc`  out  1  memory address select: 0 = PC, 1 = Result.
- `memWrite`  out  1  memory store strobe.
- `irWrite`  out  1  instruction register and oldPC load.
- `resultSrc`  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `aluSrcA`  out  2  ALU input A: 00 = PC, 01 = oldPC, 10 = rd1.
- `aluSrcB`  out  2  ALU input B: 00 = rd2, 01 = immExt, 10 = constant 4.
- `aluControl`  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `regWrite`  out  1  register-file write enable.
- `immSrc`  out  2  extender format: 00 I, 01 S, 10 B, 11 never driven by a supported op.
- `trap`  out  1  illegal instruction detected; sticky.
- `instret`  out  CNT_WIDTH  retired-instruction count.

## Operation
Supported instructions: lw (0000011), sw (0100011), R-type (0110011), I-ALU (0010011), beq/bne (1100011, funct3 000/001). Any other op or funct3 goes to TRAP.

Outputs are Moore outputs of the state, with these exceptions:
- `pcWrite` in BRANCH depends on `zero`.
- FETCH and memory-state strobes are gated by `memReady`.
- `immSrc` is combinational from `op`: lw/I-ALU → 00, sw → 01, branch → 10, otherwise 00.

Signals not listed for a state are 0.

States and outputs:
- FETCH: adrSrc=0, aluSrcA=00, aluSrcB=10, add, resultSrc=10, irWrite=pcWrite=memReady. Stays in FETCH while !memReady; otherwise → DECODE.
- DECODE: aluSrcA=01, aluSrcB=01, add (branch target into ALUOut). Next state:
  - lw/sw → MEMADR
  - R → EXECUTER
  - I-ALU → EXECUTEI
  - beq/bne → BRANCH
  - else → TRAP
- MEMADR: aluSrcA=10, aluSrcB=01, add. → MEMREAD for lw, → MEMWRITE for sw.
- MEMREAD: adrSrc=1, resultSrc=00. Holds until memReady, then → MEMWB.
- MEMWB: resultSrc=01, regWrite=1. → FETCH.
- MEMWRITE: adrSrc=1, resultSrc=00, memWrite=1 held every cycle until memReady. → FETCH.
- EXECUTER / EXECUTEI: aluSrcA=10, aluSrcB=00 or 01 respectively, funct-decoded operation. → ALUWB, or → TRAP on an illegal funct3.
- ALUWB: resultSrc=00, regWrite=1. → FETCH.
- BRANCH: aluSrcA=10, aluSrcB=00, sub, resultSrc=00, pcWrite = zero for beq, !zero for bne. → FETCH.
- TRAP: trap=1, all enables 0. Stays until rst.

Funct decode (EXECUTER/EXECUTEI):
- funct3 000: sub if R-type and funct7b5, else add.
- 010: slt.
- 110: or.
- 111: and.
- Other funct3 values are illegal.

`instret` increments by 1 on each transition from MEMWB, MEMWRITE (with memReady), ALUWB or BRANCH into FETCH. It wraps modulo 2^CNT_WIDTH.

## Timing
- Reset: on the edge with rst=1, state ← FETCH, instret ← 0, trap ← 0. While rst=1, pcWrite, irWrite, regWrite and memWrite are forced to 0 regardless of state or memReady.
- Reset mid-instruction abandons the instruction with no further writes and does not count it.
- Cycle counts with memReady=1 throughout:
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R / I-ALU: 4 cycles.
  - branch: 3 cycles.
- Each cycle with memReady=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- memReady is ignored in every other state.
- In FETCH, irWrite and pcWrite assert in the same cycle as memReady, so PC+4 and the instruction latch together.
- trap rises in the cycle after DECODE or EXECUTE sees the illegal encoding.

## Structure
- Package `ctrl_pkg` holds:
  - the state enum;
  - opcode constants;
  - resultSrc, aluSrcA, aluSrcB, immSrc and aluControl encodings;
  - the aluOp type (add / sub / funct).
- The extender imports the immSrc encoding from `ctrl_pkg`.
- Sub-module `alu_decoder` is combinational: aluOp, funct3, funct7b5, op[5] → aluControl plus an illegal flag.
- `multicycle_ctrl` contains the FSM, output decode and instret counter.

## Test plan
- Reset with memReady=1, then add x3,x1,x2 (0x002081B3): FETCH, DECODE, EXECUTER, ALUWB. regWrite=1 only in cycle 4 with aluControl=000. instret=1.
- lw with memReady low for 2 cycles in MEMREAD: 7 total cycles. resultSrc=01 and regWrite=1 in the final cycle. immSrc=00.
- sw with memReady low for 1 cycle: memWrite held high for 2 cycles, immSrc=01, no regWrite. instret increments once.
- beq with zero=1, then bne with zero=1: pcWrite=1 in the beq BRANCH cycle, pcWrite=0 in the bne BRANCH cycle. immSrc=10 and aluControl=001 in both.
- Illegal op 0x7F: trap=1 the cycle after DECODE and stays high. No enables asserted for 10 cycles. rst clears trap and returns to FETCH.
- rst asserted in MEMWRITE while memReady=1: memWrite=0 in that cycle, state FETCH next cycle, instret unchanged.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: FSM states, opcodes
// and the select/operation codes seen by the datapath and the immediate extender.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] RESULT_ALUOUT = 2'b00;
  localparam logic [1:0] RESULT_DATA   = 2'b01;
  localparam logic [1:0] RESULT_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I    = 2'b00;
  localparam logic [1:0] IMM_S    = 2'b01;
  localparam logic [1:0] IMM_B    = 2'b10;
  localparam logic [1:0] IMM_RSVD = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_t;

  // Extender format depends only on the opcode, never on the FSM state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:     return IMM_S;
      OP_BRANCH: return IMM_B;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder: maps the FSM's aluOp request plus the
// instruction's funct fields to an ALU control code and flags illegal funct3.
module alu_decoder
  import ctrl_pkg::*;
(
  input  aluop_t     alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type from I-ALU; addi never subtracts.
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// decodes all datapath selects, counts retired instructions and traps on bad encodings.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 memReady,
  output logic                 pcWrite,
  output logic                 adrSrc,
  output logic                 memWrite,
  output logic                 irWrite,
  output logic [1:0]           resultSrc,
  output logic [1:0]           aluSrcA,
  output logic [1:0]           aluSrcB,
  output logic [2:0]           aluControl,
  output logic                 regWrite,
  output logic [1:0]           immSrc,
  output logic                 trap,
  output logic [CNT_WIDTH-1:0] instret,
  output state_t               dbg_state
);

  // Handshake: memReady high in FETCH, MEMREAD or MEMWRITE means the memory
  // completed this cycle's access; the FSM advances on that same rising edge.

  state_t state;
  aluop_t alu_op;
  logic   alu_illegal;
  logic   pc_write_raw;
  logic   ir_write_raw;
  logic   reg_write_raw;
  logic   mem_write_raw;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (aluControl),
    .illegal     (alu_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      case (state)
        S_FETCH:
          if (memReady) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXECUTER;
            OP_I:         state <= S_EXECUTEI;
            OP_BRANCH:    state <= (funct3 == 3'b000 || funct3 == 3'b001) ? S_BRANCH : S_TRAP;
            default:      state <= S_TRAP;
          endcase
        end
        S_MEMADR:
          state <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:
          if (memReady) state <= S_MEMWB;
        S_MEMWRITE:
          if (memReady) begin
            state   <= S_FETCH;
            instret <= instret + CNT_WIDTH'(1);
          end
        S_EXECUTER, S_EXECUTEI:
          state <= alu_illegal ? S_TRAP : S_ALUWB;
        S_MEMWB, S_ALUWB, S_BRANCH: begin
          state   <= S_FETCH;
          instret <= instret + CNT_WIDTH'(1);
        end
        S_TRAP:
          state <= S_TRAP;
        default:
          state <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    adrSrc        = 1'b0;
    resultSrc     = RESULT_ALUOUT;
    aluSrcA       = SRCA_PC;
    aluSrcB       = SRCB_RD2;
    alu_op        = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        aluSrcB      = SRCB_FOUR;
        resultSrc    = RESULT_ALURES;
        ir_write_raw = memReady;
        pc_write_raw = memReady;
      end
      S_DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        aluSrcA = SRCA_RD1;
        aluSrcB = SRCB_IMM;
      end
      S_MEMREAD:
        adrSrc = 1'b1;
      S_MEMWB: begin
        resultSrc     = RESULT_DATA;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        aluSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        aluSrcA = SRCA_RD1;
        aluSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB:
        reg_write_raw = 1'b1;
      S_BRANCH: begin
        aluSrcA      = SRCA_RD1;
        alu_op       = ALUOP_SUB;
        pc_write_raw = funct3[0] ? ~zero : zero;
      end
      default: ;
    endcase
  end

  // Reset overrides every write enable so an abandoned instruction leaves no trace.
  assign pcWrite   = pc_write_raw & ~rst;
  assign irWrite   = ir_write_raw & ~rst;
  assign regWrite  = reg_write_raw & ~rst;
  assign memWrite  = mem_write_raw & ~rst;
  assign immSrc    = imm_src_of(op);
  assign trap      = (state == S_TRAP);
  assign dbg_state = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected output vectors are
// queued with their memReady stimulus and compared as the FSM steps through them.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  op = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        funct7b5 = 1'b0;
  logic        zero = 1'b0;
  logic        memReady = 1'b0;
  logic        pcWrite, adrSrc, memWrite, irWrite, regWrite, trap;
  logic [1:0]  resultSrc, aluSrcA, aluSrcB, immSrc;
  logic [2:0]  aluControl;
  logic [31:0] instret;
  state_t      dbg_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_instret = 0;
  logic [16:0] exp_q[$];
  logic        mr_q[$];
  logic [16:0] obs;

  multicycle_ctrl #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .memReady(memReady), .pcWrite(pcWrite), .adrSrc(adrSrc),
    .memWrite(memWrite), .irWrite(irWrite), .resultSrc(resultSrc),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluControl(aluControl),
    .regWrite(regWrite), .immSrc(immSrc), .trap(trap), .instret(instret),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  assign obs = {pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
                aluControl, regWrite, immSrc, trap};

  function automatic logic [16:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] ac, input logic rw,
                                     input logic [1:0] imm, input logic tr);
    return {pcw, adr, mw, irw, rs, sa, sb, ac, rw, imm, tr};
  endfunction

  function automatic logic [16:0] v_fetch(input logic mr, input logic [1:0] imm);
    return mk(mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, 3'b000, 0, imm, 0);
  endfunction

  function automatic logic [16:0] v_decode(input logic [1:0] imm);
    return mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, imm, 0);
  endfunction

  task automatic push(input logic mr, input logic [16:0] v);
    exp_q.push_back(v);
    mr_q.push_back(mr);
  endtask

  task automatic run_queued(input string name);
    logic [16:0] e;
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0) begin
      memReady = mr_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, obs, e);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_counts(input string name, input logic exp_trap);
    checks++;
    if (instret !== exp_instret) begin
      failures++;
      $display("FAIL %s instret: got %0d expected %0d", name, instret, exp_instret);
    end
    checks++;
    if (trap !== exp_trap) begin
      failures++;
      $display("FAIL %s trap: got %b expected %b", name, trap, exp_trap);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_instret = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    op = OP_R;
    memReady = 1'b1;
    @(posedge clk);
    #1;
    // Still in reset: FETCH selects are visible but write enables are forced low.
    push(1, mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, IMM_I, 0));
    run_queued("reset_gate");
    check_counts("reset", 0);
    rst = 1'b0;
  endtask

  task automatic test_add();
    op = OP_R; funct3 = 3'b000; funct7b5 = 1'b0;
    push(1, v_fetch(1, IMM_I));
    push(1, v_decode(IMM_I));
    push(1, mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 0, IMM_I, 0));
    push(1, mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, IMM_I, 0));
    run_queued("add");
    exp_instret++;
    check_counts("add", 0);
  endtask

  task automatic test_lw_stall();
    op = OP_LW; funct3 = 3'b010;
    push(1, v_fetch(1, IMM_I));
    push(1, v_decode(IMM_I));
    push(1, mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, IMM_I, 0));
    push(0, mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, IMM_I, 0));
    push(0, mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, IMM_I, 0));
    push(1, mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, IMM_I, 0));
    push(1, mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1, IMM_I, 0));
    run_queued("lw");
    exp_instret++;
    check_counts("lw", 0);
  endtask

  task automatic test_sw_stall();
    op = OP_SW; funct3 = 3'b010;
    push(0, v_fetch(0, IMM_S));
    push(1, v_fetch(1, IMM_S));
    push(1, v_decode(IMM_S));
    push(1, mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, IMM_S, 0));
    push(0, mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, IMM_S, 0));
    push(1, mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, IMM_S, 0));
    run_queued("sw");
    exp_instret++;
    check_counts("sw", 0);
  endtask

  task automatic test_branch();
    logic [2:0] f3_tab[4] = '{3'b000, 3'b001, 3'b001, 3'b000};
    logic       z_tab[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       pcw_tab[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    op = OP_BRANCH;
    for (int i = 0; i < 4; i++) begin
      funct3 = f3_tab[i];
      zero = z_tab[i];
      push(1, v_fetch(1, IMM_B));
      push(1, v_decode(IMM_B));
      push(1, mk(pcw_tab[i], 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, IMM_B, 0));
      run_queued($sformatf("branch%0d", i));
      exp_instret++;
      check_counts("branch", 0);
    end
    zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] op_tab[6] = '{OP_I, OP_I, OP_I, OP_I, OP_R, OP_R};
    logic [2:0] f3_tab[6] = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b000, 3'b010};
    logic       f7_tab[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] ac_tab[6] = '{3'b000, 3'b101, 3'b011, 3'b010, 3'b001, 3'b101};
    int stalls;
    for (int i = 0; i < 6; i++) begin
      op = op_tab[i]; funct3 = f3_tab[i]; funct7b5 = f7_tab[i];
      stalls = $urandom_range(0, 2);
      for (int s = 0; s < stalls; s++) push(0, v_fetch(0, IMM_I));
      push(1, v_fetch(1, IMM_I));
      push($urandom_range(0, 1), v_decode(IMM_I));
      push($urandom_range(0, 1), mk(0, 0, 0, 0, 2'b00, 2'b10,
           (op_tab[i] == OP_I) ? 2'b01 : 2'b00, ac_tab[i], 0, IMM_I, 0));
      push($urandom_range(0, 1), mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, IMM_I, 0));
      run_queued($sformatf("b2b%0d", i));
      exp_instret++;
      check_counts("b2b", 0);
    end
    funct7b5 = 1'b0;
  endtask

  task automatic test_trap();
    op = 7'h7F; funct3 = 3'b000;
    push(1, v_fetch(1, IMM_I));
    push(1, v_decode(IMM_I));
    for (int i = 0; i < 10; i++)
      push($urandom_range(0, 1), mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, IMM_I, 1));
    run_queued("trap_op");
    check_counts("trap_sticky", 1);
    do_reset();
    check_counts("trap_cleared", 0);
    // Illegal branch funct3 is caught in DECODE as well.
    op = OP_BRANCH; funct3 = 3'b010;
    push(1, v_fetch(1, IMM_B));
    push(1, v_decode(IMM_B));
    push(1, mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, IMM_B, 1));
    run_queued("trap_branch");
    do_reset();
    check_counts("trap_branch_cleared", 0);
  endtask

  task automatic test_reset_mid();
    op = OP_SW; funct3 = 3'b010;
    push(1, v_fetch(1, IMM_S));
    push(1, v_decode(IMM_S));
    push(1, mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, IMM_S, 0));
    run_queued("rst_mid_pre");
    rst = 1'b1;
    push(1, mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, IMM_S, 0));
    run_queued("rst_mid_memwrite");
    rst = 1'b0;
    push(1, v_fetch(1, IMM_S));
    run_queued("rst_mid_fetch");
    check_counts("rst_mid", 0);
    // Finish a full add afterwards so the counter is seen resuming from zero.
    op = OP_R; funct3 = 3'b000;
    push(1, v_decode(IMM_I));
    push(1, mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 0, IMM_I, 0));
    push(1, mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, IMM_I, 0));
    run_queued("rst_mid_add");
    exp_instret++;
    check_counts("rst_mid_add", 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_stall();
    test_sw_stall();
    test_branch();
    test_back_to_back();
    test_trap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
